// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache refill sequencer
package cache_pkg;
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;
    localparam int WORD_BYTES = 4;
    function automatic int line_off_w(input int words);
        return $clog2(words * WORD_BYTES);
    endfunction
endpackage

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: round-robin I/D miss sequencer driving a single memory port
module cache_refill_ctrl import cache_pkg::*; #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_we,
    output logic              fill_sel,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_done,
    output logic              d_done,
    output logic              busy
);
    localparam int OFF_W = line_off_w(WORDS_PER_LINE);
    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(WORD_BYTES - 1);
    state_t state;
    logic owner, last_grant;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wdata;
    logic [BEAT_W-1:0] beat;
    logic pick_d, req_store;
    logic [ADDR_W-1:0] req_addr;
    // D wins only when I is idle or I had the previous grant
    assign pick_d = d_req & (~i_req | (last_grant == OWNER_I));
    assign req_addr = pick_d ? d_addr : i_addr;
    assign req_store = pick_d & d_we;
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
            last_grant <= OWNER_D;
            owner <= OWNER_I;
            base <= '0;
            wdata <= '0;
            beat <= '0;
        end else begin
            case (state)
                IDLE: if (i_req | d_req) begin
                    owner <= pick_d;
                    base <= req_addr & (req_store ? WORD_MASK : LINE_MASK);
                    wdata <= d_wdata;
                    beat <= '0;
                    state <= req_store ? WRITE : FILL;
                end
                FILL: if (mem_ready) begin
                    beat <= beat + 1'b1;
                    if (beat == BEAT_W'(WORDS_PER_LINE - 1)) state <= DONE;
                end
                WRITE: if (mem_ready) state <= DONE;
                DONE: begin
                    last_grant <= owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // base is line aligned, so OR-ing the beat offset never carries out of the line
    assign mem_rd = state == FILL;
    assign mem_wr = state == WRITE;
    assign mem_addr = mem_rd ? (base | ADDR_W'({beat, 2'b00})) : mem_wr ? base : '0;
    assign mem_wdata = mem_wr ? wdata : '0;
    assign fill_we = mem_rd & mem_ready;
    assign fill_sel = mem_rd & owner;
    assign fill_addr = mem_addr;
    assign fill_data = mem_rdata;
    assign i_done = (state == DONE) & (owner == OWNER_I);
    assign d_done = (state == DONE) & (owner == OWNER_D);
    assign busy = state != IDLE;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed tables, corner sequences and random traffic
// checked against a transaction-level reference model
module tb_cache_refill_ctrl;
    localparam int WPL = 4;
    logic CLK = 1'b0;
    logic CLR;
    logic i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] mem_addr, mem_wdata, fill_addr, fill_data;
    logic mem_rd, mem_wr, fill_we, fill_sel, i_done, d_done, busy;

    always #5 CLK = ~CLK;

    cache_refill_ctrl #(.WORDS_PER_LINE(WPL), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .CLR(CLR),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_sel(fill_sel), .fill_addr(fill_addr), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    int tests = 0, fails = 0;
    bit saw_i, saw_d;
    logic [31:0] fill_log[$];
    bit done_log[$];

    // reference: a transaction is either in flight (active), completing (done) or absent
    bit m_act, m_done, m_owner, m_store, m_last;
    logic [31:0] m_base, m_data;
    int m_idx;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_done = 0; m_last = 1; m_owner = 0; m_store = 0; m_idx = 0;
        m_base = 0; m_data = 0;
    endtask

    task automatic check_model();
        bit rd, wr;
        rd = m_act && !m_store;
        wr = m_act && m_store;
        chk("mem_rd", {31'b0, mem_rd}, {31'b0, rd});
        chk("mem_wr", {31'b0, mem_wr}, {31'b0, wr});
        chk("mem_addr", mem_addr, rd ? m_base + 32'(4 * m_idx) : wr ? m_base : 32'h0);
        chk("mem_wdata", mem_wdata, wr ? m_data : 32'h0);
        chk("fill_we", {31'b0, fill_we}, {31'b0, rd && mem_ready});
        if (rd && mem_ready) begin
            chk("fill_sel", {31'b0, fill_sel}, {31'b0, m_owner});
            chk("fill_addr", fill_addr, m_base + 32'(4 * m_idx));
            chk("fill_data", fill_data, mem_rdata);
        end
        chk("i_done", {31'b0, i_done}, {31'b0, m_done && !m_owner});
        chk("d_done", {31'b0, d_done}, {31'b0, m_done && m_owner});
        chk("busy", {31'b0, busy}, {31'b0, m_act || m_done});
    endtask

    task automatic model_step();
        bit pd;
        logic [31:0] a;
        if (CLR) model_reset();
        else if (m_done) begin
            m_last = m_owner;
            m_done = 0;
        end else if (m_act) begin
            if (mem_ready) begin
                if (m_store || m_idx == WPL - 1) begin
                    m_act = 0;
                    m_done = 1;
                end else m_idx++;
            end
        end else if (i_req || d_req) begin
            pd = d_req && (!i_req || m_last == 0);
            a = pd ? d_addr : i_addr;
            m_owner = pd;
            m_store = pd && d_we;
            m_data = d_wdata;
            m_idx = 0;
            m_base = m_store ? a - a % 4 : a - a % (WPL * 4);
            m_act = 1;
        end
    endtask

    task automatic tick();
        #1;
        check_model();
        saw_i = i_done;
        saw_d = d_done;
        if (fill_we) fill_log.push_back(fill_addr);
        if (i_done) done_log.push_back(1'b0);
        if (d_done) done_log.push_back(1'b1);
        model_step();
        @(negedge CLK);
    endtask

    task automatic chk_idle_zero(string tag);
        #1;
        chk({tag, "_rd"}, {31'b0, mem_rd}, 0);
        chk({tag, "_wr"}, {31'b0, mem_wr}, 0);
        chk({tag, "_fwe"}, {31'b0, fill_we}, 0);
        chk({tag, "_sel"}, {31'b0, fill_sel}, 0);
        chk({tag, "_done"}, {30'b0, i_done, d_done}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_faddr"}, fill_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    // each requester holds its line until it sees its done pulse, icnt/dcnt times
    task automatic serve(int icnt, logic [31:0] ia, int dcnt, bit dwe, logic [31:0] da, logic [31:0] wd);
        int n = 0;
        i_addr = ia; d_addr = da; d_we = dwe; d_wdata = wd; mem_ready = 1;
        while ((icnt > 0 || dcnt > 0) && n < 100) begin
            i_req = icnt > 0;
            d_req = dcnt > 0;
            mem_rdata = $urandom;
            tick();
            if (saw_i) icnt--;
            if (saw_d) dcnt--;
            n++;
        end
        i_req = 0; d_req = 0;
        chk("serve_timeout", 32'(icnt + dcnt), 0);
        tick();
    endtask

    typedef struct {
        bit i_req, d_req, d_we;
        logic [31:0] addr, wdata;
        bit rdy, e_rd, e_wr;
        logic [31:0] e_addr;
        bit e_fwe, e_id, e_dd;
    } vec_t;
    vec_t tv[14];

    initial begin
        bit ip, dp;
        tv[0]  = '{1, 0, 0, 32'h1238, 0, 1, 0, 0, 32'h0,    0, 0, 0};
        tv[1]  = '{1, 0, 0, 32'h1238, 0, 1, 1, 0, 32'h1230, 1, 0, 0};
        tv[2]  = '{1, 0, 0, 32'h1238, 0, 1, 1, 0, 32'h1234, 1, 0, 0};
        tv[3]  = '{1, 0, 0, 32'h1238, 0, 1, 1, 0, 32'h1238, 1, 0, 0};
        tv[4]  = '{1, 0, 0, 32'h1238, 0, 1, 1, 0, 32'h123C, 1, 0, 0};
        tv[5]  = '{1, 0, 0, 32'h1238, 0, 1, 0, 0, 32'h0,    0, 1, 0};
        tv[6]  = '{0, 0, 0, 32'h1238, 0, 1, 0, 0, 32'h0,    0, 0, 0};
        tv[7]  = '{0, 1, 1, 32'h43, 32'hDEADBEEF, 0, 0, 0, 32'h0,  0, 0, 0};
        tv[8]  = '{0, 1, 1, 32'h43, 32'hDEADBEEF, 0, 0, 1, 32'h40, 0, 0, 0};
        tv[9]  = '{0, 1, 1, 32'h43, 32'hDEADBEEF, 0, 0, 1, 32'h40, 0, 0, 0};
        tv[10] = '{0, 1, 1, 32'h43, 32'hDEADBEEF, 0, 0, 1, 32'h40, 0, 0, 0};
        tv[11] = '{0, 1, 1, 32'h43, 32'hDEADBEEF, 1, 0, 1, 32'h40, 0, 0, 0};
        tv[12] = '{0, 1, 1, 32'h43, 32'hDEADBEEF, 1, 0, 0, 32'h0,  0, 0, 1};
        tv[13] = '{0, 0, 0, 32'h43, 32'hDEADBEEF, 1, 0, 0, 32'h0,  0, 0, 0};

        CLR = 1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        repeat (2) @(negedge CLK);
        CLR = 0;
        model_reset();
        chk_idle_zero("reset");
        tick();

        for (int k = 0; k < 14; k++) begin
            i_req = tv[k].i_req; d_req = tv[k].d_req; d_we = tv[k].d_we;
            i_addr = tv[k].addr; d_addr = tv[k].addr; d_wdata = tv[k].wdata;
            mem_ready = tv[k].rdy; mem_rdata = $urandom;
            #1;
            chk($sformatf("tv%0d_rd", k), {31'b0, mem_rd}, {31'b0, tv[k].e_rd});
            chk($sformatf("tv%0d_wr", k), {31'b0, mem_wr}, {31'b0, tv[k].e_wr});
            chk($sformatf("tv%0d_addr", k), mem_addr, tv[k].e_addr);
            chk($sformatf("tv%0d_wdata", k), mem_wdata, tv[k].e_wr ? tv[k].wdata : 32'h0);
            chk($sformatf("tv%0d_fwe", k), {31'b0, fill_we}, {31'b0, tv[k].e_fwe});
            chk($sformatf("tv%0d_idone", k), {31'b0, i_done}, {31'b0, tv[k].e_id});
            chk($sformatf("tv%0d_ddone", k), {31'b0, d_done}, {31'b0, tv[k].e_dd});
            tick();
        end

        // tie after reset: I first; I re-requests at once so D wins the next tie
        CLR = 1; tick(); CLR = 0;
        fill_log.delete(); done_log.delete();
        serve(2, 32'h0, 1, 0, 32'h80, 0);
        chk("rr_count", 32'(done_log.size()), 3);
        if (done_log.size() == 3) begin
            chk("rr_first", {31'b0, done_log[0]}, 0);
            chk("rr_second", {31'b0, done_log[1]}, 1);
            chk("rr_third", {31'b0, done_log[2]}, 0);
        end
        chk("rr_fills", 32'(fill_log.size()), 12);
        if (fill_log.size() == 12)
            for (int k = 0; k < 8; k++)
                chk($sformatf("rr_fill%0d", k), fill_log[k], k < 4 ? 32'(4 * k) : 32'h80 + 32'(4 * (k - 4)));

        // wait states on beat 2
        fill_log.delete(); done_log.delete();
        i_req = 1; i_addr = 32'h200; mem_ready = 1;
        repeat (3) tick();
        mem_ready = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("wait_addr", mem_addr, 32'h208);
            chk("wait_fwe", {31'b0, fill_we}, 0);
            chk("wait_rd", {31'b0, mem_rd}, 1);
            tick();
        end
        mem_ready = 1;
        repeat (3) tick();
        i_req = 0;
        tick();
        chk("wait_fills", 32'(fill_log.size()), 4);
        if (fill_log.size() == 4)
            for (int k = 0; k < 4; k++) chk($sformatf("wait_fill%0d", k), fill_log[k], 32'h200 + 32'(4 * k));
        chk("wait_done", 32'(done_log.size()), 1);

        // reset mid-burst
        fill_log.delete(); done_log.delete();
        i_req = 1; i_addr = 32'h344; mem_ready = 1;
        repeat (2) tick();
        CLR = 1;
        tick();
        CLR = 0; i_req = 0;
        chk_idle_zero("clr");
        repeat (3) tick();
        chk("clr_nodone", 32'(done_log.size()), 0);
        i_req = 1;
        tick();
        #1;
        chk("clr_restart", mem_addr, 32'h340);
        serve(1, 32'h344, 0, 0, 0, 0);

        // random traffic
        ip = 0; dp = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!ip && $urandom_range(3) == 0) begin ip = 1; i_addr = $urandom; end
            if (!dp && $urandom_range(3) == 0) begin
                dp = 1; d_addr = $urandom; d_we = $urandom_range(1); d_wdata = $urandom;
            end
            i_req = ip; d_req = dp;
            mem_ready = $urandom_range(9) < 7;
            mem_rdata = $urandom;
            CLR = $urandom_range(299) == 0;
            tick();
            if (saw_i) ip = 0;
            if (saw_d) dp = 0;
        end
        CLR = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss/refill sequencer that sits between the instruction-side and data-side caches and the single shared main-memory port. It arbitrates round-robin between an I-side line-fill request and a D-side request (line fill or write-through store). It then drives memory word by word: a line-aligned sequential burst for fills, a single beat for stores. Fill words are streamed into the owning cache's data array, and the owner gets a one-cycle completion pulse.

## Interface
- WORDS_PER_LINE, 4: words per cache line; power of two, ≥2.
- ADDR_W, 32: byte-address width.
- DATA_W, 32: word width; word = 4 bytes.

- CLK  in  1  clock; all state updates on posedge.
- CLR  in  1  reset, synchronous, active-high.
- i_req  in  1  I-cache miss; held high until i_done.
- i_addr  in  ADDR_W  I-side miss byte address.
- d_req  in  1  D-side request; held high until d_done.
- d_we  in  1  D request type: 1 = write-through store, 0 = line fill.
- d_addr  in  ADDR_W  D-side byte address.
- d_wdata  in  DATA_W  store data.
- mem_addr  out  ADDR_W  memory word address, low 2 bits always 0.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts/returns the current beat this cycle.
- mem_rdata  in  DATA_W  read data, valid when mem_rd & mem_ready.
- fill_we  out  1  write one word into the cache array.
- fill_sel  out  1  target array: 0 = I-cache, 1 = D-cache.
- fill_addr  out  ADDR_W  word address being filled (equals mem_addr).
- fill_data  out  DATA_W  fill word (equals mem_rdata).
- i_done  out  1  one-cycle pulse: I transaction complete.
- d_done  out  1  one-cycle pulse: D transaction complete.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both: grant the side not granted last; last_grant resets to D, so I wins the first tie.
  - Grant latches owner, d_we, base address and store data.
  - Fill, or D request with d_we=0: base = addr with low log2(WORDS_PER_LINE*4) bits zeroed; beat counter = 0; go to FILL.
  - D request with d_we=1: base = {addr[ADDR_W-1:2],2'b00}; go to WRITE.
- FILL:
  - mem_rd=1, mem_addr = base + 4*beat.
  - On mem_rd & mem_ready, the beat is accepted:
    - fill_we=1 combinationally that cycle, with fill_addr=mem_addr, fill_data=mem_rdata, fill_sel=owner.
    - beat increments at the edge.
  - Last beat (beat = WORDS_PER_LINE-1) accepted: go to DONE.
  - mem_ready low: hold address and strobe (wait state). No beat skipped or repeated.
- WRITE:
  - mem_wr=1, mem_addr=base, mem_wdata=latched data.
  - On mem_ready: go to DONE. fill_we stays 0; the cache is not updated here.
- DONE:
  - Pulse i_done or d_done (owner only) for exactly one cycle.
  - Update last_grant = owner; return to IDLE.
- Requests deasserted mid-transaction are ignored; the granted transaction always completes.
- New requests are sampled only in IDLE. The earliest re-grant is the cycle after DONE.
- Beat counter is log2(WORDS_PER_LINE) bits. Address arithmetic stays inside the line, so there is no carry out of the line offset.

## Timing
- Reset (CLR high at an edge, from any state, including mid-burst or mid-write):
  - State goes to IDLE and last_grant to D.
  - All outputs read 0 the next cycle: mem_rd, mem_wr, fill_we, i_done, d_done, busy, mem_addr, mem_wdata, fill_addr, fill_sel.
  - The partial transaction is abandoned without a done pulse.
- Request-to-first-strobe latency: 1 cycle (IDLE grant edge → FILL/WRITE).
- Fill with mem_ready constant 1: WORDS_PER_LINE consecutive beats, then DONE.
  - Total from grant edge to done pulse: WORDS_PER_LINE+1 cycles.
- Store with zero wait: strobe 1 cycle, done the following cycle.
- mem_rd and mem_wr are never high together. Both are 0 in IDLE and DONE.

## Structure
- Shared package cache_pkg: state enum (IDLE, FILL, WRITE, DONE), OWNER_I/OWNER_D constants, WORD_BYTES=4, line-offset width function.
- No sub-module required. An optional rr_arb2 (2-way round-robin arbiter) is acceptable if reused elsewhere.

## Test plan
- I fill, i_addr=0x0000_1238, mem_ready=1:
  - mem_addr 0x1230, 0x1234, 0x1238, 0x123C on 4 consecutive cycles, fill_we each cycle, fill_sel=0.
  - i_done pulses the next cycle; d_done stays 0.
- i_req and d_req (fill, d_addr=0x80) asserted together after reset:
  - I line 0x...0 served first, then D line 0x80–0x8C.
  - Both re-asserted afterward: D served first (round-robin).
- Store, d_we=1, d_addr=0x43, d_wdata=0xDEADBEEF, mem_ready low 3 cycles:
  - mem_wr held 4 cycles at mem_addr 0x40 with data 0xDEADBEEF, fill_we never asserted.
  - d_done one cycle after ready.
- Fill at 0x200 with mem_ready low on beat 2 for 2 cycles:
  - mem_addr holds 0x208, fill_we low during the wait.
  - Exactly 4 fill_we pulses, addresses 0x200–0x20C.
- CLR asserted on beat 1 of a fill:
  - Next cycle all outputs 0, no done pulse.
  - Fresh i_req restarts at the line base.
